// File: rtl/presubaddor_pkg.sv
// Shared types and default constants for the presub-mult-or operand issuer.
package presubaddor_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } issue_state_t;

  localparam int unsigned DefaultWidth   = 10;
  localparam int unsigned DefaultIi      = 2;
  localparam int unsigned DefaultLatency = 2;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/presubaddor_operand_fifo.sv
// Operand-tuple FIFO: power-of-two ring buffer with occupancy count, no bypass path.
module presubaddor_operand_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/presubaddor_operand_issuer.sv
// Buffers operand tuples and issues them to a fixed-latency presub-mult-or pipeline
// no faster than once every II cycles; res_valid tracks the pipeline output.
module presubaddor_operand_issuer
  import presubaddor_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned II      = DefaultIi,
  parameter int unsigned LATENCY = DefaultLatency
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [WIDTH-1:0]           in_c,
  input  logic [WIDTH-1:0]           in_d,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           a,
  output logic [WIDTH-1:0]           b,
  output logic [WIDTH-1:0]           c,
  output logic [WIDTH-1:0]           d,
  output logic                       issue,
  output logic                       res_valid,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned TupleW   = 4 * WIDTH;
  localparam int unsigned HoldW    = cnt_width(II);
  localparam int unsigned HoldLast = (II > 1) ? II - 2 : 0;
  localparam int unsigned SrW      = (LATENCY > 0) ? LATENCY : 1;

  logic [TupleW-1:0] fifo_rdata, operand_q;
  logic              fifo_full, fifo_empty, push, pop;
  issue_state_t      state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              issue_q;
  logic [SrW-1:0]    res_sr_q;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  presubaddor_operand_fifo #(
    .Width (TupleW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_a, in_b, in_c, in_d}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // HOLD spans II-1 cycles starting with the issue cycle, so the next pop lands II edges later.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          hold_d = '0;
          if (II > 1) state_d = StHold;
        end
      end
      StHold: begin
        if (hold_q == HoldW'(HoldLast)) begin
          state_d = StIdle;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      issue_q   <= 1'b0;
      operand_q <= '0;
      res_sr_q  <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      issue_q  <= pop;
      res_sr_q <= (res_sr_q << 1) | SrW'(issue_q);
      if (pop) operand_q <= fifo_rdata;
    end
  end

  assign issue     = issue_q;
  assign res_valid = (LATENCY == 0) ? issue_q : res_sr_q[SrW-1];
  assign {a, b, c, d} = operand_q;

endmodule
